// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - DMEM_ADDR_W / DMEM_DATA_W / DMEM_DEPTH_LOG2 : default geometry
//   - dmem_state_e : arbitration states; the dump states only exist when
//                    DMEM_DUMP_EN is defined
//   - in_range()   : true when a processor address hits the implemented bytes
package dmem_pkg;

    localparam int DMEM_ADDR_W     = 16;
    localparam int DMEM_DATA_W     = 8;
    localparam int DMEM_DEPTH_LOG2 = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2
`ifdef DMEM_DUMP_EN
        ,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_OUT = 3'd4
`endif
    } dmem_state_e;

    // Anything above the implemented depth is a miss, not an alias.
    function automatic logic in_range(input logic [DMEM_ADDR_W-1:0] addr);
        return addr[DMEM_ADDR_W-1:DMEM_DEPTH_LOG2] == '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous byte RAM with a registered read port.
// A write and a read of the same address in one cycle returns the old data.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : data of addr_i sampled at the previous edge
module dmem_array #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1 << AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the processor data port, plus a host load
// stream (operand preload) and an optional dump stream (result readout).
// Only one master drives the array at a time; the state machine decides who.
//
// Optional feature macro: DMEM_DUMP_EN builds the dump states and out-stream.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cpu_addr/cpu_wr/cpu_wdata : processor byte access (honoured in RUN only)
//   cpu_rdata                 : registered read data, 0 outside RUN / on miss
//   cpu_start, cpu_halt       : enter / leave RUN
//   load_start, in_*          : host load stream into mem[0..]
//   dump_start/base/len, out_*: host dump stream of mem[base +: len]
//   busy, load_ovf            : not-idle flag, sticky load-pointer wrap
//
// state       | meaning
// ST_IDLE     | no master; start requests accepted here only
// ST_LOAD     | host stream writes mem[ptr], ptr++
// ST_RUN      | processor owns the array
// ST_DUMP_RD  | array reading mem[base+idx]
// ST_DUMP_OUT | beat presented, waiting for out_ready
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
    parameter int DATA_W     = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_start,
    input  logic              cpu_halt,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              load_ovf
);

    dmem_state_e           state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  load_ovf_q, load_ovf_d;
    logic                  cpu_rd_ok_q;
    logic                  cpu_in_range;

    logic                  arr_we;
    logic [DEPTH_LOG2-1:0] arr_addr;
    logic [DATA_W-1:0]     arr_wdata;
    logic [DATA_W-1:0]     arr_rdata;

    assign cpu_in_range = in_range(cpu_addr);

`ifdef DMEM_DUMP_EN
    logic [DEPTH_LOG2-1:0] dump_base_q, dump_base_d;
    logic [ADDR_W-1:0]     dump_len_q, dump_len_d;
    logic [ADDR_W-1:0]     dump_idx_q, dump_idx_d;
    logic                  out_last_q, out_last_d;
    logic                  unused_dump_hi;

    assign unused_dump_hi = ^dump_base[ADDR_W-1:DEPTH_LOG2];
`else
    logic unused_dump;

    assign unused_dump = ^{dump_start, dump_base, dump_len, out_ready};
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        load_ovf_d = load_ovf_q;
`ifdef DMEM_DUMP_EN
        dump_base_d = dump_base_q;
        dump_len_d  = dump_len_q;
        dump_idx_d  = dump_idx_q;
        out_last_d  = out_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    ptr_d      = '0;
                    load_ovf_d = 1'b0;
                end
`ifdef DMEM_DUMP_EN
                else if (dump_start) begin
                    dump_base_d = dump_base[DEPTH_LOG2-1:0];
                    dump_len_d  = dump_len;
                    dump_idx_d  = '0;
                    // A zero-length dump is accepted but produces no beats.
                    if (dump_len != '0) begin
                        state_d = ST_DUMP_RD;
                    end
                end
`endif
                else if (cpu_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    ptr_d = ptr_q + DEPTH_LOG2'(1);
                    if (&ptr_q) begin
                        load_ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef DMEM_DUMP_EN
            ST_DUMP_RD: begin
                state_d    = ST_DUMP_OUT;
                out_last_d = (dump_idx_q == dump_len_q - ADDR_W'(1));
            end
            ST_DUMP_OUT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        dump_idx_d = dump_idx_q + ADDR_W'(1);
                        state_d    = ST_DUMP_RD;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            load_ovf_q  <= 1'b0;
            cpu_rd_ok_q <= 1'b0;
`ifdef DMEM_DUMP_EN
            dump_base_q <= '0;
            dump_len_q  <= '0;
            dump_idx_q  <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            load_ovf_q  <= load_ovf_d;
            cpu_rd_ok_q <= cpu_in_range;
`ifdef DMEM_DUMP_EN
            dump_base_q <= dump_base_d;
            dump_len_q  <= dump_len_d;
            dump_idx_q  <= dump_idx_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    // Array port mux. In DUMP_OUT the address is held on the current beat so
    // the re-read keeps out_data stable under backpressure.
    always_comb begin
        arr_addr  = cpu_addr[DEPTH_LOG2-1:0];
        arr_wdata = cpu_wdata;
        arr_we    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                arr_addr  = ptr_q;
                arr_wdata = in_data;
                arr_we    = in_valid;
            end
            ST_RUN: begin
                arr_we = cpu_wr & cpu_in_range;
            end
`ifdef DMEM_DUMP_EN
            ST_DUMP_RD, ST_DUMP_OUT: begin
                arr_addr = dump_base_q + dump_idx_q[DEPTH_LOG2-1:0];
            end
`endif
            default: ;
        endcase
        if (rst) begin
            arr_we = 1'b0;
        end
    end

    dmem_array #(
        .AW (DEPTH_LOG2),
        .DW (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    assign cpu_rdata = (state_q == ST_RUN && cpu_rd_ok_q) ? arr_rdata : '0;
    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign load_ovf  = load_ovf_q;

`ifdef DMEM_DUMP_EN
    assign out_valid = (state_q == ST_DUMP_OUT);
    assign out_data  = out_valid ? arr_rdata : '0;
    assign out_last  = out_valid & out_last_q;
`else
    assign out_valid = 1'b0;
    assign out_data  = '0;
    assign out_last  = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    localparam int ADDR_W     = 16;
    localparam int DEPTH_LOG2 = 12;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_start, cpu_halt, load_start;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_data;
    logic              dump_start;
    logic [ADDR_W-1:0] dump_base, dump_len;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;
    logic              busy, load_ovf;

    always #5 clk = ~clk;

    data_memory_responder #(
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_start  (cpu_start),
        .cpu_halt   (cpu_halt),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .dump_start (dump_start),
        .dump_base  (dump_base),
        .dump_len   (dump_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .load_ovf   (load_ovf)
    );

    // Reference model: byte contents, which bytes hold a defined value,
    // and the number of beats since the last load_start.
    logic [7:0] mem_m   [DEPTH];
    bit         known_m [DEPTH];
    int         load_beats_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_beats_m = 0;
        chk("load_busy", 32'(busy), 1);
        chk("load_ovf_cleared", 32'(load_ovf), 0);
    endtask

    task automatic stream_byte(input logic [7:0] d, input bit last, input bit gaps);
        logic [11:0] ix;
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
        end
        chk("load_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        ix = 12'(load_beats_m % DEPTH);
        mem_m[ix]   = d;
        known_m[ix] = 1'b1;
        load_beats_m++;
        chk("load_ovf", 32'(load_ovf), 32'(load_beats_m >= DEPTH));
        if (last) begin
            chk("load_end_in_ready", 32'(in_ready), 0);
            chk("load_end_busy", 32'(busy), 0);
        end
    endtask

    task automatic cpu_op(input logic [15:0] a, input bit wr, input logic [7:0] d, input string tag);
        logic [7:0] expv;
        bit         k;
        bit         inr;
        inr = (32'(a) < DEPTH);
        if (inr) begin
            expv = mem_m[a[11:0]];
            k    = known_m[a[11:0]];
        end else begin
            expv = 8'h00;
            k    = 1'b1;
        end
        cpu_addr  = a;
        cpu_wr    = wr;
        cpu_wdata = d;
        tick();
        cpu_wr = 1'b0;
        if (wr && inr) begin
            mem_m[a[11:0]]   = d;
            known_m[a[11:0]] = 1'b1;
        end
        if (k) chk(tag, 32'(cpu_rdata), 32'(expv));
    endtask

    task automatic run_start();
        cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        chk("run_busy", 32'(busy), 1);
    endtask

    task automatic run_halt();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("halt_busy", 32'(busy), 0);
        chk("halt_rdata_zero", 32'(cpu_rdata), 0);
    endtask

`ifdef DMEM_DUMP_EN
    task automatic dump_check(input int base, input int len, input int stall0, input bit rnd, input bit with_cpu);
        int waited;
        dump_base  = 16'(base);
        dump_len   = 16'(len);
        dump_start = 1'b1;
        cpu_start  = with_cpu;
        tick();
        dump_start = 1'b0;
        cpu_start  = 1'b0;
        if (len == 0) begin
            chk("dump0_busy", 32'(busy), 0);
            tick();
            chk("dump0_valid", 32'(out_valid), 0);
            return;
        end
        chk("dump_busy", 32'(busy), 1);
        chk("dump_first_gap", 32'(out_valid), 0);
        for (int i = 0; i < len; i++) begin
            logic [7:0] e;
            int stall;
            e = mem_m[12'((base + i) % DEPTH)];
            stall = (i == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
            waited = 0;
            while (!out_valid && waited < 4) begin
                tick();
                waited++;
            end
            chk("dump_valid", 32'(out_valid), 1);
            if (!out_valid) return;
            if (i == 0) chk("dump_first_latency", 32'(waited), 1);
            chk("dump_data", 32'(out_data), 32'(e));
            chk("dump_last", 32'(out_last), 32'(i == len - 1));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("dump_hold_valid", 32'(out_valid), 1);
                chk("dump_hold_data", 32'(out_data), 32'(e));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("dump_done_busy", 32'(busy), 0);
        chk("dump_done_valid", 32'(out_valid), 0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_wr = 1'b0; cpu_wdata = '0;
        cpu_start = 1'b0; cpu_halt = 1'b0; load_start = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        dump_start = 1'b0; dump_base = '0; dump_len = '0; out_ready = 1'b0;
        load_beats_m = 0;

        repeat (3) tick();
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_ovf", 32'(load_ovf), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        // All three requests at once: load must win.
        dump_len   = 16'd3;
        load_start = 1'b1; cpu_start = 1'b1; dump_start = 1'b1;
        tick();
        load_start = 1'b0; cpu_start = 1'b0; dump_start = 1'b0;
        load_beats_m = 0;
        chk("prio_load_in_ready", 32'(in_ready), 1);
        chk("prio_load_out_valid", 32'(out_valid), 0);
        stream_byte(8'h11, 1'b0, 1'b1);
        stream_byte(8'h22, 1'b0, 1'b1);
        stream_byte(8'h33, 1'b1, 1'b1);

        // A valid beat while idle must not be taken.
        in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("idle_in_valid_busy", 32'(busy), 0);
        chk("idle_in_ready", 32'(in_ready), 0);

        run_start();
        cpu_op(16'h0001, 1'b0, 8'h00, "rd_addr1");
        cpu_op(16'h0004, 1'b1, 8'h5A, "wr_addr4");
        cpu_op(16'h0004, 1'b0, 8'h00, "rd_addr4");
        cpu_op(16'h1000, 1'b1, 8'hFF, "oor_wr");
        cpu_op(16'h1000, 1'b0, 8'h00, "oor_rd");
        cpu_op(16'h0000, 1'b0, 8'h00, "rd_addr0_after_oor");
        cpu_op(16'h0004, 1'b1, 8'h66, "rdw_old_data");
        cpu_op(16'h0004, 1'b0, 8'h00, "rdw_new_data");

        // Halt in the same cycle as a write: the write still lands.
        cpu_addr = 16'h0007; cpu_wr = 1'b1; cpu_wdata = 8'hA5; cpu_halt = 1'b1;
        tick();
        cpu_wr = 1'b0; cpu_halt = 1'b0;
        mem_m[7] = 8'hA5; known_m[7] = 1'b1;
        chk("halt_wr_busy", 32'(busy), 0);
        chk("halt_wr_rdata", 32'(cpu_rdata), 0);

        // Processor write while idle is dropped.
        cpu_addr = 16'h0002; cpu_wr = 1'b1; cpu_wdata = 8'h77;
        tick();
        cpu_wr = 1'b0;
        chk("idle_rdata", 32'(cpu_rdata), 0);

`ifdef DMEM_DUMP_EN
        dump_check(0, 3, 4, 1'b0, 1'b1);
        dump_check(7, 0, 0, 1'b0, 1'b0);
`else
        dump_base = '0; dump_len = 16'd3; dump_start = 1'b1; cpu_start = 1'b1;
        tick();
        dump_start = 1'b0; cpu_start = 1'b0;
        chk("nodump_run_taken", 32'(busy), 1);
        chk("nodump_valid0", 32'(out_valid), 0);
        tick();
        chk("nodump_valid1", 32'(out_valid), 0);
        chk("nodump_data", 32'(out_data), 0);
        chk("nodump_last", 32'(out_last), 0);
        run_halt();
`endif

        run_start();
        cpu_op(16'h0007, 1'b0, 8'h00, "halt_write_kept");
        cpu_op(16'h0002, 1'b0, 8'h00, "idle_write_ignored");
        run_halt();

        // Reset in the middle of a load.
        start_load();
        for (int i = 0; i < 20; i++) stream_byte(8'($urandom), 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 0);
        chk("rst_mid_ovf", 32'(load_ovf), 0);
        rst = 1'b0;
        tick();
        load_beats_m = 0;

        run_start();
        for (int i = 0; i < 20; i++) cpu_op(16'(i), 1'b0, 8'h00, "rst_preserved");
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(4096, 65535));
            else a = 16'($urandom_range(0, 31));
            cpu_op(a, 1'($urandom_range(0, 1)), 8'($urandom), "run_rand");
        end
        run_halt();

        // Fill past the end of the array: pointer wraps, byte 4097 lands at 0.
        start_load();
        for (int i = 0; i <= DEPTH; i++) stream_byte(8'($urandom), 1'(i == DEPTH), 1'b0);

        run_start();
        cpu_op(16'h0000, 1'b0, 8'h00, "ovf_wrap_byte");
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, DEPTH - 1));
            else a = 16'($urandom);
            cpu_op(a, 1'($urandom_range(0, 1)), 8'($urandom), "run_rand_full");
        end
        run_halt();
        chk("ovf_sticky", 32'(load_ovf), 1);

`ifdef DMEM_DUMP_EN
        dump_check(DEPTH - 2, 5, 1, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            dump_check(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 6)),
                       int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
        end
        chk("ovf_after_dumps", 32'(load_ovf), 1);
`endif

        start_load();
        stream_byte(8'h42, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
